// File: rtl/remote_comm_if.sv
// Host-side handshake bundle for remote_comm: command request in, status/response out.
interface remote_comm_if;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        resp_tmo;
  logic        busy;

  modport master (
    output snd_cmd, cmd,
    input  cmd_snt, resp_rdy, resp, resp_tmo, busy
  );

  modport slave (
    input  snd_cmd, cmd,
    output cmd_snt, resp_rdy, resp, resp_tmo, busy
  );
endinterface

// File: rtl/remote_comm.sv
// Knight's Tour host transmitter: sends a 16-bit command as two UART bytes (high first),
// then waits for a one-byte reply or times out. Contains its own 8N1 UART transceiver.
module rc_uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);
  localparam int BW = $clog2(BAUD_DIV * 2);

  // transmitter
  logic [9:0]    tx_shft;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic          tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= '1;
      tx_baud <= '0;
      tx_bit  <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else if (trmt) begin
      tx_shft <= {1'b1, tx_data, 1'b0};
      tx_baud <= '0;
      tx_bit  <= '0;
      tx_busy <= 1'b1;
      tx_done <= 1'b0;
    end else if (tx_busy) begin
      if (tx_baud == BW'(BAUD_DIV - 1)) begin
        tx_baud <= '0;
        tx_shft <= {1'b1, tx_shft[9:1]};
        tx_bit  <= tx_bit + 4'd1;
        // tx_done rises only once the full stop bit has been on the line
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end
      end else begin
        tx_baud <= tx_baud + BW'(1);
      end
    end
  end

  assign TX = tx_shft[0];

  // receiver
  logic          rx_ff1, rx_ff2;
  logic [8:0]    rx_shft;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic          rx_busy;
  logic          rx_start, rx_sample, rx_last;

  assign rx_start  = !rx_busy && !rx_ff2;
  assign rx_sample = rx_busy && (rx_baud == '0);
  assign rx_last   = rx_sample && (rx_bit == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_shft <= '0;
      rx_baud <= '0;
      rx_bit  <= '0;
      rx_busy <= 1'b0;
      rx_rdy  <= 1'b0;
    end else begin
      rx_ff1 <= RX;
      rx_ff2 <= rx_ff1;
      // first sample lands mid-way through data bit 0, skipping the start bit
      if (rx_start) begin
        rx_busy <= 1'b1;
        rx_baud <= BW'(BAUD_DIV + BAUD_DIV / 2 - 1);
        rx_bit  <= '0;
      end else if (rx_sample) begin
        rx_shft <= {rx_ff2, rx_shft[8:1]};
        rx_baud <= BW'(BAUD_DIV - 1);
        rx_bit  <= rx_bit + 4'd1;
        if (rx_last) rx_busy <= 1'b0;
      end else if (rx_busy) begin
        rx_baud <= rx_baud - BW'(1);
      end

      if (rx_last)                    rx_rdy <= 1'b1;
      else if (clr_rx_rdy || rx_start) rx_rdy <= 1'b0;
    end
  end

  assign rx_data = rx_shft[7:0];
endmodule

module remote_comm #(
  parameter int RESP_TIMEOUT = 1_000_000,
  parameter int BAUD_DIV     = 2604
) (
  input  logic         clk,
  input  logic         rst_n,
  remote_comm_if.slave host,
  output logic         TX,
  input  logic         RX
);
  localparam int CW = $clog2(RESP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} state_t;

  state_t        state, nxt;
  logic          trmt, tx_done, rx_rdy, clr_rx_rdy;
  logic [7:0]    tx_data, rx_data;
  logic [7:0]    cmd_lo, resp_q;
  logic          cmd_snt_q, resp_rdy_q, resp_tmo_q;
  logic [CW-1:0] cnt;
  logic          ld_cmd, set_snt, cap_resp, set_tmo;

  rc_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .TX         (TX),
    .RX         (RX),
    .clr_rx_rdy (clr_rx_rdy),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // A received byte is always acknowledged; only WAIT_RESP keeps it.
  always_comb begin
    nxt        = state;
    trmt       = 1'b0;
    tx_data    = cmd_lo;
    clr_rx_rdy = rx_rdy;
    ld_cmd     = 1'b0;
    set_snt    = 1'b0;
    cap_resp   = 1'b0;
    set_tmo    = 1'b0;
    unique case (state)
      IDLE: if (host.snd_cmd) begin
        trmt    = 1'b1;
        tx_data = host.cmd[15:8];
        ld_cmd  = 1'b1;
        nxt     = TX_HI;
      end
      TX_HI: if (tx_done) begin
        trmt = 1'b1;
        nxt  = TX_LO;
      end
      TX_LO: if (tx_done) begin
        set_snt = 1'b1;
        nxt     = WAIT_RESP;
      end
      WAIT_RESP: if (rx_rdy) begin
        cap_resp = 1'b1;
        nxt      = IDLE;
      end else if (cnt == CW'(RESP_TIMEOUT - 1)) begin
        set_tmo = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_lo     <= '0;
      resp_q     <= '0;
      cmd_snt_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
      resp_tmo_q <= 1'b0;
      cnt        <= '0;
    end else begin
      if (ld_cmd) begin
        cmd_lo     <= host.cmd[7:0];
        cmd_snt_q  <= 1'b0;
        resp_rdy_q <= 1'b0;
        resp_tmo_q <= 1'b0;
      end
      if (set_snt) cmd_snt_q <= 1'b1;
      if (cap_resp) begin
        resp_q     <= rx_data;
        resp_rdy_q <= 1'b1;
      end
      if (set_tmo) resp_tmo_q <= 1'b1;

      if (set_snt)                 cnt <= '0;
      else if (state == WAIT_RESP) cnt <= cnt + CW'(1);
    end
  end

  assign host.cmd_snt  = cmd_snt_q;
  assign host.resp_rdy = resp_rdy_q;
  assign host.resp     = resp_q;
  assign host.resp_tmo = resp_tmo_q;
  assign host.busy     = (state != IDLE);
endmodule

// File: tb/tb_remote_comm.sv
// Directed + randomized bench for remote_comm: TX is decoded by a UART monitor, RX is driven
// by a byte generator, and results are compared against a transaction-level model.
module tb_remote_comm;
  localparam int B = 8;
  localparam int T = 1000;

  logic clk = 1'b0;
  logic rst_n;
  logic RX = 1'b1;
  logic TX;

  remote_comm_if hif ();

  remote_comm #(.RESP_TIMEOUT(T), .BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (hif.slave),
    .TX    (TX),
    .RX    (RX)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  byte unsigned tx_q[$];
  int frames = 0;
  logic [7:0] exp_resp = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // serial decoder on TX, sampling mid-bit
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (TX === 1'b0) begin
        frames++;
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = TX;
        end
        repeat (B) @(negedge clk);
        tx_q.push_back(b);
      end
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] c);
    @(negedge clk);
    hif.snd_cmd = 1'b1;
    hif.cmd     = c;
    @(negedge clk);
    hif.snd_cmd = 1'b0;
    hif.cmd     = 16'($urandom);
  endtask

  task automatic wait_cmd_snt(output int n);
    n = 0;
    while (n < 30 * B) begin
      @(posedge clk); #1;
      n++;
      if (hif.cmd_snt) break;
    end
    if (!hif.cmd_snt) check("cmd_snt_bound", 32'(hif.cmd_snt), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < T + 20 * B) begin
      if (hif.resp_rdy || hif.resp_tmo) break;
      @(posedge clk); #1;
      n++;
    end
    if (!(hif.resp_rdy || hif.resp_tmo)) check("done_bound", 32'd0, 32'd1);
  endtask

  // each accepted command must appear on the wire as exactly {hi, lo}
  task automatic check_bytes(input string tag, input logic [15:0] c);
    logic [7:0] g0, g1;
    g0 = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    g1 = (tx_q.size() > 1) ? tx_q[1] : 8'hxx;
    check({tag, "_nbytes"}, 32'(tx_q.size()), 32'd2);
    check({tag, "_hi"}, 32'(g0), 32'(c[15:8]));
    check({tag, "_lo"}, 32'(g1), 32'(c[7:0]));
    tx_q.delete();
  endtask

  task automatic check_idle_status(input string tag, input logic rdy, input logic tmo);
    check({tag, "_resp_rdy"}, 32'(hif.resp_rdy), 32'(rdy));
    check({tag, "_resp_tmo"}, 32'(hif.resp_tmo), 32'(tmo));
    check({tag, "_resp"}, 32'(hif.resp), 32'(exp_resp));
    check({tag, "_busy"}, 32'(hif.busy), 32'd0);
  endtask

  initial begin : stim
    int n;
    logic [15:0] c;
    logic [7:0] r;
    hif.snd_cmd = 1'b0;
    hif.cmd     = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_snt", 32'(hif.cmd_snt), 32'd0);
    check("rst_resp_rdy", 32'(hif.resp_rdy), 32'd0);
    check("rst_resp_tmo", 32'(hif.resp_tmo), 32'd0);
    check("rst_resp", 32'(hif.resp), 32'h00);
    check("rst_busy", 32'(hif.busy), 32'd0);
    check("rst_tx", 32'(TX), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // basic send with exact send-time, then reply
    issue(16'h29A5);
    check("t1_busy", 32'(hif.busy), 32'd1);
    wait_cmd_snt(n);
    check("t1_send_time", 32'(n), 32'(20 * B + 2));
    check_bytes("t1", 16'h29A5);
    send_rx(8'hA5);
    exp_resp = 8'hA5;
    wait_done(n);
    check_idle_status("t2", 1'b1, 1'b0);

    // no reply: timeout exactly T clocks after cmd_snt, then immediate re-accept
    c = 16'($urandom);
    issue(c);
    wait_cmd_snt(n);
    check_bytes("t3", c);
    n = 0;
    while (!hif.resp_tmo && n < T + 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t3_tmo_time", 32'(n), 32'(T));
    check_idle_status("t3", 1'b0, 1'b1);
    issue(16'h1234);
    check("t4_reaccept_busy", 32'(hif.busy), 32'd1);
    check("t4_tmo_cleared", 32'(hif.resp_tmo), 32'd0);

    // snd_cmd during the low byte is ignored
    frames = 0;
    repeat (15 * B - 1) @(negedge clk);
    hif.snd_cmd = 1'b1;
    hif.cmd     = 16'hFFFF;
    @(negedge clk);
    hif.snd_cmd = 1'b0;
    wait_cmd_snt(n);
    repeat (12 * B) @(negedge clk);
    check("t4_frames", 32'(frames), 32'd1);
    check_bytes("t4", 16'h1234);
    r = 8'($urandom);
    send_rx(r);
    exp_resp = r;
    wait_done(n);
    check_idle_status("t4", 1'b1, 1'b0);

    // stray byte in IDLE is dropped
    send_rx(8'h55);
    repeat (2 * B) @(negedge clk);
    check_idle_status("t5_stray", 1'b1, 1'b0);
    issue(16'h0001);
    check("t5_rdy_cleared", 32'(hif.resp_rdy), 32'd0);
    wait_cmd_snt(n);
    check_bytes("t5", 16'h0001);
    send_rx(8'h3C);
    exp_resp = 8'h3C;
    wait_done(n);
    check_idle_status("t5", 1'b1, 1'b0);

    // reset in the middle of the low byte
    issue(16'($urandom));
    repeat (15 * B) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_resp = 8'h00;
    check("t6_tx", 32'(TX), 32'd1);
    check("t6_cmd_snt", 32'(hif.cmd_snt), 32'd0);
    check_idle_status("t6_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * B) @(negedge clk);
    tx_q.delete();
    issue(16'hBEEF);
    wait_cmd_snt(n);
    check("t6_send_time", 32'(n), 32'(20 * B + 2));
    check_bytes("t6", 16'hBEEF);
    r = 8'($urandom);
    send_rx(r);
    exp_resp = r;
    wait_done(n);
    check_idle_status("t6", 1'b1, 1'b0);

    // random transactions: reply after a random delay or let it time out
    for (int k = 0; k < 8; k++) begin
      logic reply;
      c = 16'($urandom);
      reply = ($urandom_range(0, 2) != 0);
      issue(c);
      check("rnd_busy", 32'(hif.busy), 32'd1);
      wait_cmd_snt(n);
      check("rnd_send_time", 32'(n), 32'(20 * B + 2));
      check_bytes("rnd", c);
      if (reply) begin
        repeat ($urandom_range(0, 400)) @(negedge clk);
        r = 8'($urandom);
        send_rx(r);
        exp_resp = r;
      end
      wait_done(n);
      check_idle_status("rnd", reply, !reply);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
